// File: rtl/palette_bank_lut_if.sv
// ---------------------------------------------------------------------------
// palette_bank_lut_if
// Pixel lookup stream between the sprite ROM index output and the palette.
//
// Handshake: valid-only stream, there is no ready. The palette takes one
// index per cycle whenever pix_valid is high and never stalls. Each accepted
// index produces exactly one result with rgb_valid high two cycles later, in
// order. When rgb_valid is low, Red/Green/Blue and transparent are all 0.
//
// Signals
//   pix_valid    index valid this cycle              (master -> slave)
//   pix_idx      palette index                       (master -> slave)
//   Red/Green/Blue looked-up colour, 8 bits each     (slave -> master)
//   rgb_valid    colour valid                        (slave -> master)
//   transparent  rgb_valid and looked-up index == 0  (slave -> master)
// ---------------------------------------------------------------------------
interface palette_bank_lut_if #(
    parameter int IDX_W = 3
);
    logic             pix_valid;
    logic [IDX_W-1:0] pix_idx;
    logic [7:0]       Red;
    logic [7:0]       Green;
    logic [7:0]       Blue;
    logic             rgb_valid;
    logic             transparent;

    modport master (
        output pix_valid, pix_idx,
        input  Red, Green, Blue, rgb_valid, transparent
    );

    modport slave (
        input  pix_valid, pix_idx,
        output Red, Green, Blue, rgb_valid, transparent
    );
endinterface

// File: rtl/palette_bank_lut.sv
// ---------------------------------------------------------------------------
// palette_bank_lut
// Runtime-writable, multi-bank sprite colour palette with a registered
// two-stage lookup. Index 0 is reported as transparent. Bank switches are
// requested at any time but only take effect on frame_start, so a sprite
// never changes palette mid-frame.
//
// Optional feature: define PALETTE_FLASH_EN to build the hit-flash logic
// (forces non-transparent pixels to white on alternate frames).
//
// Ports
//   Clk, Reset      clock, synchronous active-high reset
//   pix             lookup stream (palette_bank_lut_if.slave)
//   frame_start     1-cycle pulse at start of vblank
//   bank_req        requested bank, latched when bank_req_valid
//   wr_en/wr_bank/wr_idx/wr_rgb   single-entry palette write
//   flash_trig      start hit-flash (unused without PALETTE_FLASH_EN)
//   bank_active     bank currently used for lookups
//   pend_flag       bank FSM state (1 = PENDING)
//   flash_state     flash FSM state (0 IDLE, 1 ON, 2 OFF; 0 when not built)
// ---------------------------------------------------------------------------
module palette_bank_lut #(
    parameter int IDX_W        = 3,
    parameter int BANKS        = 4,
    parameter int BANK_W       = (BANKS > 1) ? $clog2(BANKS) : 1,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    palette_bank_lut_if.slave   pix,
    input  logic                frame_start,
    input  logic [BANK_W-1:0]   bank_req,
    input  logic                bank_req_valid,
    input  logic                wr_en,
    input  logic [BANK_W-1:0]   wr_bank,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [23:0]         wr_rgb,
    input  logic                flash_trig,
    output logic [BANK_W-1:0]   bank_active,
    output logic                pend_flag,
    output logic [1:0]          flash_state
);
    localparam int ENTRIES = 1 << IDX_W;
    // One extra bit so BANKS itself is representable for the range checks.
    localparam logic [BANK_W:0] BANK_LIMIT = BANKS[BANK_W:0];

    localparam logic [0:0] ST_STEADY  = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    function automatic logic [23:0] default_rgb(input int e);
        case (e)
            1:       default_rgb = 24'hE4F1F6;
            2:       default_rgb = 24'hEEDC02;
            3:       default_rgb = 24'h3A4D55;
            4:       default_rgb = 24'h8DBFD0;
            5:       default_rgb = 24'h7C8CB4;
            6:       default_rgb = 24'hDAA701;
            7:       default_rgb = 24'h677495;
            default: default_rgb = 24'h000000;
        endcase
    endfunction

    logic [23:0]       mem [BANKS][ENTRIES];
    logic [0:0]        bank_state;
    logic [BANK_W-1:0] pend_bank;
    logic              req_ok;
    logic              wr_ok;
    logic              s1_valid;
    logic [IDX_W-1:0]  s1_idx;
    logic [BANK_W-1:0] s1_bank;
    logic [23:0]       rd_rgb;
    logic              flash_white;

    // Requests/writes naming a bank that does not exist are dropped.
    assign req_ok = bank_req_valid && ({1'b0, bank_req} < BANK_LIMIT);
    assign wr_ok  = wr_en && ({1'b0, wr_bank} < BANK_LIMIT);

    // Palette storage. Reset reloads the bank 0 defaults and clears the rest.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    mem[b][e] <= (b == 0) ? default_rgb(e) : 24'h000000;
                end
            end
        end else if (wr_ok) begin
            mem[wr_bank][wr_idx] <= wr_rgb;
        end
    end

    // Bank FSM. A request arriving together with frame_start is applied
    // directly; otherwise the last pending request is applied at frame_start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bank_state  <= ST_STEADY;
            pend_bank   <= '0;
            bank_active <= '0;
        end else if (frame_start && req_ok) begin
            bank_active <= bank_req;
            pend_bank   <= bank_req;
            bank_state  <= ST_STEADY;
        end else if (frame_start && (bank_state == ST_PENDING)) begin
            bank_active <= pend_bank;
            bank_state  <= ST_STEADY;
        end else if (req_ok) begin
            pend_bank  <= bank_req;
            bank_state <= ST_PENDING;
        end
    end

    assign pend_flag = (bank_state == ST_PENDING);

`ifdef PALETTE_FLASH_EN
    localparam logic [1:0] FL_IDLE = 2'd0;
    localparam logic [1:0] FL_ON   = 2'd1;
    localparam logic [1:0] FL_OFF  = 2'd2;
    localparam logic [7:0] FLASH_LOAD = FLASH_FRAMES[7:0];

    logic [7:0] flash_cnt;

    // A trigger always (re)starts the flash, even on a frame_start cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flash_state <= FL_IDLE;
            flash_cnt   <= 8'd0;
        end else if (flash_trig) begin
            flash_state <= FL_ON;
            flash_cnt   <= FLASH_LOAD;
        end else if (frame_start && (flash_state != FL_IDLE)) begin
            if (flash_cnt == 8'd1) begin
                flash_state <= FL_IDLE;
                flash_cnt   <= 8'd0;
            end else begin
                flash_cnt   <= flash_cnt - 8'd1;
                flash_state <= (flash_state == FL_ON) ? FL_OFF : FL_ON;
            end
        end
    end

    assign flash_white = (flash_state == FL_ON);
`else
    logic unused_flash;

    assign flash_state  = 2'd0;
    assign flash_white  = 1'b0;
    assign unused_flash = ^{flash_trig, FLASH_FRAMES[7:0]};
`endif

    // Stage 2 read; a same-edge write lands after this read (old value seen).
    assign rd_rgb = mem[s1_bank][s1_idx];

    // Stage 1 captures index plus the bank in force now, so a later bank
    // switch cannot affect pixels already in flight. Stage 2 reads the table.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid        <= 1'b0;
            s1_idx          <= '0;
            s1_bank         <= '0;
            pix.rgb_valid   <= 1'b0;
            pix.transparent <= 1'b0;
            pix.Red         <= 8'd0;
            pix.Green       <= 8'd0;
            pix.Blue        <= 8'd0;
        end else begin
            s1_valid        <= pix.pix_valid;
            s1_idx          <= pix.pix_idx;
            s1_bank         <= bank_active;
            pix.rgb_valid   <= s1_valid;
            pix.transparent <= s1_valid && (s1_idx == '0);
            if (!s1_valid) begin
                {pix.Red, pix.Green, pix.Blue} <= 24'h000000;
            end else if (flash_white && (s1_idx != '0)) begin
                {pix.Red, pix.Green, pix.Blue} <= 24'hFFFFFF;
            end else begin
                {pix.Red, pix.Green, pix.Blue} <= rd_rgb;
            end
        end
    end
endmodule
